// File: rtl/qtree_pkg.sv
// Shared types for the quadtree lookup pipeline: RAM word layout and the
// in-order position decoder used by the tree loader.
`timescale 1ns/1ps
package qtree_pkg;

  localparam int QT_STAGES     = 4;
  localparam int QT_DATA_WIDTH = 16;

  typedef struct packed {
    logic [QT_DATA_WIDTH-1:0] l;
    logic [QT_DATA_WIDTH-1:0] m;
    logic [QT_DATA_WIDTH-1:0] r;
  } ram_data_t;

  typedef struct packed {
    logic [7:0]  level;
    logic [1:0]  slot;
    logic [31:0] addr;
  } pos_dec_t;

  // p is the 1-based in-order position; trailing zero base-4 digits select the level.
  function automatic pos_dec_t pos_decode(input logic [31:0] p, input int stages);
    pos_dec_t   d;
    int         t;
    logic       found;
    logic [1:0] digit;
    t     = 0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found) begin
        if (p[2*i +: 2] != 2'd0) found = 1'b1;
        else t = t + 1;
      end
    end
    digit   = 2'(p >> (2*t));
    d.slot  = digit - 2'd1;
    d.level = 8'(stages - 1 - t);
    d.addr  = p >> (2*(t+1));
    return d;
  endfunction

endpackage

// File: rtl/qtree_loader.sv
// Builds a complete 4-ary search tree from a sorted key stream and emits
// one-hot per-stage RAM writes; short streams are padded with all-ones keys.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// LOAD  | accepting keys from the stream, one per cycle
// PAD   | generating all-ones keys until the last leaf is written
// DONE  | tree complete; start_i begins a new load
`timescale 1ns/1ps
module qtree_loader
  import qtree_pkg::*;
#(
  parameter int STAGES     = QT_STAGES,
  parameter int DATA_WIDTH = QT_DATA_WIDTH,
  parameter int ADDR_WIDTH = (STAGES > 1) ? 2*(STAGES-1) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    key_valid_i,
  input  logic [DATA_WIDTH-1:0]   key_data_i,
  input  logic                    key_last_i,
  output logic                    key_ready_o,
  output logic [STAGES-1:0]       wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [3*DATA_WIDTH-1:0] wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    order_err_o
);

  localparam int PW = 2*STAGES;
  localparam int LW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [PW-1:0] LAST_POS = {{(PW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [PW-1:0]           r_pos;
  logic [DATA_WIDTH-1:0]   r_hold_l [STAGES];
  logic [DATA_WIDTH-1:0]   r_hold_m [STAGES];
  logic [DATA_WIDTH-1:0]   r_prev_key;
  logic                    r_have_prev;
  logic                    r_order_err;
  logic [STAGES-1:0]       r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [3*DATA_WIDTH-1:0] r_wr_data;

  logic [PW-1:0]           w_p;
  pos_dec_t                w_dec;
  logic [LW-1:0]           w_level;
  logic [1:0]              w_slot;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_unused_dec;
  logic                    w_accept, w_consume, w_final, w_enter_load;
  logic [DATA_WIDTH-1:0]   w_key;

  assign w_p          = r_pos + 1'b1;
  assign w_dec        = pos_decode(32'(w_p), STAGES);
  assign w_level      = w_dec.level[LW-1:0];
  assign w_slot       = w_dec.slot;
  assign w_addr       = w_dec.addr[ADDR_WIDTH-1:0];
  assign w_unused_dec = ^{w_dec.level[7:LW], w_dec.addr[31:ADDR_WIDTH]};

  assign w_accept     = (r_state == S_LOAD) && key_valid_i;
  assign w_consume    = w_accept || (r_state == S_PAD);
  assign w_key        = (r_state == S_PAD) ? '1 : key_data_i;
  assign w_final      = (r_pos == LAST_POS);
  assign w_enter_load = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    key_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_LOAD;
      S_LOAD: begin
        key_ready_o = 1'b1;
        busy_o      = 1'b1;
        if (w_accept) begin
          if (w_final)         w_state_nxt = S_DONE;
          else if (key_last_i) w_state_nxt = S_PAD;
        end
      end
      S_PAD: begin
        busy_o = 1'b1;
        if (w_final) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slot 2 closes a node: l/m come from the hold registers of the same level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pos       <= '0;
      r_prev_key  <= '0;
      r_have_prev <= 1'b0;
      r_order_err <= 1'b0;
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_hold_l[i] <= '0;
        r_hold_m[i] <= '0;
      end
    end else begin
      r_wr_en <= '0;
      if (w_enter_load) begin
        r_pos       <= '0;
        r_order_err <= 1'b0;
        r_have_prev <= 1'b0;
      end else if (w_consume) begin
        if (!w_final) r_pos <= r_pos + 1'b1;
        case (w_slot)
          2'd0: r_hold_l[w_level] <= w_key;
          2'd1: r_hold_m[w_level] <= w_key;
          2'd2: begin
            r_wr_en   <= STAGES'(1) << w_level;
            r_wr_addr <= w_addr;
            r_wr_data <= {r_hold_l[w_level], r_hold_m[w_level], w_key};
          end
          default: ;
        endcase
        if (w_accept) begin
          if (r_have_prev && (key_data_i < r_prev_key)) r_order_err <= 1'b1;
          r_prev_key  <= key_data_i;
          r_have_prev <= 1'b1;
        end
      end
    end
  end

  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign order_err_o = r_order_err;

endmodule

// File: tb/tb_qtree_loader.sv
// Directed bench for qtree_loader with a two-stage tree: 15 positions,
// five node writes per load, checked against hand-built write tables.
`timescale 1ns/1ps
module tb_qtree_loader;
  import qtree_pkg::*;

  localparam int S  = 2;
  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          key_valid = 1'b0;
  logic          key_last = 1'b0;
  logic [DW-1:0] key_data = '0;
  logic          key_ready;
  logic [S-1:0]  wr_en;
  logic [AW-1:0] wr_addr;
  logic [3*DW-1:0] wr_data;
  logic          busy, done, order_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pad_cycles = 0;

  typedef struct {
    int            cyc;
    logic [S-1:0]  en;
    logic [AW-1:0] addr;
    logic [3*DW-1:0] data;
    logic          done;
  } wr_rec_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] key;
  } acc_rec_t;

  wr_rec_t  wr_q[$];
  acc_rec_t acc_q[$];

  logic [S-1:0]    exp_en   [5];
  logic [AW-1:0]   exp_addr [5];
  logic [3*DW-1:0] exp_data [5];
  logic [DW-1:0]   kv       [15];

  always #5 clk = ~clk;

  qtree_loader #(.STAGES(S), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .key_valid_i (key_valid),
    .key_data_i  (key_data),
    .key_last_i  (key_last),
    .key_ready_o (key_ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .busy_o      (busy),
    .done_o      (done),
    .order_err_o (order_err)
  );

  // Accepts are stamped with the cycle in which their write strobe would appear.
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) acc_q.push_back('{cyc: cyc + 1, key: key_data});
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (wr_en != '0) wr_q.push_back('{cyc: cyc, en: wr_en, addr: wr_addr, data: wr_data, done: done});
    if (busy && !key_ready) pad_cycles <= pad_cycles + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] mk(input logic [DW-1:0] l, input logic [DW-1:0] m,
                                         input logic [DW-1:0] r);
    ram_data_t d;
    d.l = l;
    d.m = m;
    d.r = r;
    return d;
  endfunction

  task automatic set_exp(input int i, input logic [S-1:0] en, input logic [AW-1:0] addr,
                         input logic [3*DW-1:0] data);
    exp_en[i]   = en;
    exp_addr[i] = addr;
    exp_data[i] = data;
  endtask

  task automatic exp_full(input logic [DW-1:0] first_r, input logic [DW-1:0] first_m);
    set_exp(0, 2'b10, 2'd0, mk(16'd10, first_m, first_r));
    set_exp(1, 2'b10, 2'd1, mk(16'd50, 16'd60, 16'd70));
    set_exp(2, 2'b10, 2'd2, mk(16'd90, 16'd100, 16'd110));
    set_exp(3, 2'b01, 2'd0, mk(16'd40, 16'd80, 16'd120));
    set_exp(4, 2'b10, 2'd3, mk(16'd130, 16'd140, 16'd150));
  endtask

  task automatic kv_linear();
    for (int i = 0; i < 15; i++) kv[i] = 16'(10 * (i + 1));
  endtask

  task automatic clear_logs();
    wr_q.delete();
    acc_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_key(input logic [DW-1:0] k, input logic last, input int gap);
    int n;
    n = 0;
    key_valid = 1'b1;
    key_data  = k;
    key_last  = last;
    while (!key_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    key_valid = 1'b0;
    key_last  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_stream(input int n, input logic last_at_end, input int gap);
    for (int i = 0; i < n; i++) send_key(kv[i], last_at_end && (i == n - 1), gap);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
      chk($sformatf("%s_en%0d", tag, i),   64'(wr_q[i].en),   64'(exp_en[i]));
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_q[i].addr), 64'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), 64'(wr_q[i].data), 64'(exp_data[i]));
    end
  endtask

  task automatic check_latency(input string tag);
    for (int i = 0; i < wr_q.size(); i++) begin
      int ac;
      ac = -1;
      foreach (acc_q[j]) if (acc_q[j].key == wr_q[i].data[DW-1:0]) ac = acc_q[j].cyc;
      chk($sformatf("%s_lat%0d", tag, i), 64'(wr_q[i].cyc), 64'(ac));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    kv_linear();
    #3;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_ready", 64'(key_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(order_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // full 15-key stream
    clear_logs();
    exp_full(16'd30, 16'd20);
    do_start();
    chk("s1_busy", 64'(busy), 64'd1);
    chk("s1_ready", 64'(key_ready), 64'd1);
    run_stream(15, 1'b1, 0);
    wait_done("s1_done");
    chk("s1_err", 64'(order_err), 64'd0);
    check_writes("s1");
    check_latency("s1");
    if (wr_q.size() == 5) chk("s1_last_in_done", 64'(wr_q[4].done), 64'd1);

    // short stream with padding
    clear_logs();
    for (int i = 0; i < 5; i++) kv[i] = 16'(i + 1);
    set_exp(0, 2'b10, 2'd0, mk(16'd1, 16'd2, 16'd3));
    set_exp(1, 2'b10, 2'd1, mk(16'd5, 16'hFFFF, 16'hFFFF));
    set_exp(2, 2'b10, 2'd2, mk(16'hFFFF, 16'hFFFF, 16'hFFFF));
    set_exp(3, 2'b01, 2'd0, mk(16'd4, 16'hFFFF, 16'hFFFF));
    set_exp(4, 2'b10, 2'd3, mk(16'hFFFF, 16'hFFFF, 16'hFFFF));
    p0 = pad_cycles;
    do_start();
    run_stream(5, 1'b1, 0);
    chk("s2_pad_ready", 64'(key_ready), 64'd0);
    wait_done("s2_done");
    chk("s2_pad_cycles", 64'(pad_cycles - p0), 64'd10);
    check_writes("s2");

    // valid toggling every other cycle
    clear_logs();
    kv_linear();
    exp_full(16'd30, 16'd20);
    do_start();
    run_stream(15, 1'b1, 1);
    wait_done("s3_done");
    check_writes("s3");
    check_latency("s3");

    // out-of-order key
    clear_logs();
    kv[1] = 16'd30;
    kv[2] = 16'd20;
    exp_full(16'd20, 16'd30);
    do_start();
    send_key(kv[0], 1'b0, 0);
    send_key(kv[1], 1'b0, 0);
    chk("s4_err_before", 64'(order_err), 64'd0);
    send_key(kv[2], 1'b0, 0);
    chk("s4_err_rise", 64'(order_err), 64'd1);
    for (int i = 3; i < 15; i++) send_key(kv[i], i == 14, 0);
    wait_done("s4_done");
    chk("s4_err_sticky", 64'(order_err), 64'd1);
    check_writes("s4");
    do_start();
    chk("s4_err_cleared", 64'(order_err), 64'd0);

    // reset in the middle of a load, while a write strobe is active
    kv_linear();
    run_stream(7, 1'b0, 0);
    chk("s5_wr_before", 64'(wr_en), 64'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rst_wr_en", 64'(wr_en), 64'd0);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    chk("s5_rst_ready", 64'(key_ready), 64'd0);
    chk("s5_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    exp_full(16'd30, 16'd20);
    do_start();
    run_stream(15, 1'b1, 0);
    wait_done("s5_done");
    check_writes("s5");
    check_latency("s5");

    // start ignored mid-load; stream without last stops at the final position
    clear_logs();
    do_start();
    for (int i = 0; i < 4; i++) send_key(kv[i], 1'b0, 0);
    start = 1'b1;
    send_key(kv[4], 1'b0, 0);
    start = 1'b0;
    for (int i = 5; i < 15; i++) send_key(kv[i], 1'b0, 0);
    wait_done("s6_done");
    check_writes("s6");
    key_valid = 1'b1;
    key_data  = 16'd160;
    repeat (3) @(negedge clk);
    chk("s6_extra_ready", 64'(key_ready), 64'd0);
    chk("s6_extra_done", 64'(done), 64'd1);
    chk("s6_accepts", 64'(acc_q.size()), 64'd15);
    key_valid = 1'b0;
    @(negedge clk);
    chk("s6_no_extra_wr", 64'(wr_q.size()), 64'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
